pwm_deadtime_gen: RTL
=====================

// Module: pwm_deadtime_gen
// PURPOSE
//  Downstream stage of the PWM generator. Converts the single registered PWM bit into a
//  complementary high-side/low-side gate-drive pair with programmable dead time.
//  Guarantees hs_out and ls_out are never high together.
//  Swallows PWM pulses shorter than the dead band and flags each one.
// PARAMETERS
//  DT_BITS   4   width of dead-time config / counter; dead band = 1..2**DT_BITS-1 clk_in cycles
// PORTS
//  clk_in     in   1        clock
//  rst        in   1        reset, asynchronous, active-high
//  en         in   1        output enable; 0 forces both gates low
//  pwm_in     in   1        PWM bit from generator (registered, clk_in domain)
//  dt_cfg     in   DT_BITS  dead time in clk_in cycles; 0 treated as 1
//  hs_out     out  1        high-side gate drive (follows pwm_in high phase)
//  ls_out     out  1        low-side gate drive (follows pwm_in low phase)
//  dt_active  out  1        1 while in either dead-band state
//  swallow    out  1        1-cycle pulse when an in-progress dead band is aborted
// BEHAVIOUR
//  Reset: state=S_OFF; hs_out=ls_out=dt_active=swallow=0; cnt=0; pwm_s=0; dt_lat=0.
//  Input stage: pwm_s <= pwm_in each edge. All decisions use pwm_s, never pwm_in directly.
//  Outputs: registered, decoded from next_state.
//   - hs_out=1 only in S_HIGH; ls_out=1 only in S_LOW.
//   - dt_active=1 in S_DT_RISE/S_DT_FALL.
//  Dead-band entry:
//   - dt_lat <= (dt_cfg==0 ? 1 : dt_cfg); cnt <= dt_lat value.
//   - dt_cfg is ignored at all other times, so mid-band changes take effect at the next entry.
//  States / transitions (evaluated each edge; en=0 overrides all -> S_OFF):
//   S_OFF    : both low. en=1 & pwm_s=1 -> S_DT_RISE; en=1 & pwm_s=0 -> S_DT_FALL.
//   S_LOW    : ls=1. pwm_s=1 -> S_DT_RISE.
//   S_DT_RISE: both low; cnt--.
//              pwm_s=0 -> S_LOW, swallow=1 for one cycle.
//              else cnt==1 -> S_HIGH.
//   S_HIGH   : hs=1. pwm_s=0 -> S_DT_FALL.
//   S_DT_FALL: both low; cnt--.
//              pwm_s=1 -> S_HIGH, swallow=1 for one cycle.
//              else cnt==1 -> S_LOW.
//  Timing: pwm_in edge visible at edge n -> pwm_s at n+1 -> active gate drops at n+2.
//   - Opposite gate rises at n+2+D, D = dt_lat.
//   - Both-low window is exactly D cycles.
//  Aborted band: the gate being turned off is restored next edge.
//   - Both-low time is < D; the new gate is never driven.
//  Pulse shorter than D cycles at pwm_s: fully swallowed, gate outputs unchanged.
//  Invariant: hs_out & ls_out == 0 every cycle, including en toggles and reset release.
//  en falling: both outputs low on the next edge, no dead band applied (turn-off only).
//  Reset mid-operation: outputs forced low asynchronously; restarts from S_OFF.
//  cnt width DT_BITS, never wraps (loaded >=1, leaves state at 1).
// TESTING
//  1 rst high, toggle pwm_in -> hs_out=ls_out=dt_active=0 throughout.
//  2 en=1, dt_cfg=3, pwm_in 0->1 held 20 cycles -> ls_out falls at n+2.
//    hs_out rises at n+5; both-low exactly 3 cycles; dt_active high those 3 cycles.
//  3 dt_cfg=0, square-wave pwm_in period 16 -> dead band 1 cycle on each transition;
//    hs/ls never overlap.
//  4 dt_cfg=5, 2-cycle high pulse on pwm_in from S_LOW -> hs_out stays 0.
//    ls_out restored after 2-cycle gap; swallow pulses once.
//  5 dt_cfg changed 3->7 during S_DT_RISE -> current band stays 3; next band 7.
//  6 Random pwm_in/en/dt_cfg 10k cycles + async rst pulses -> assert !(hs_out&ls_out).
//    Every hs/ls transition is separated by >=1 both-low cycle.

Source files
------------

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: complementary high/low gate drive from one PWM bit with programmable dead time.
// Outputs are registered and decoded from the next state, so the two gates can never overlap.
module pwm_deadtime_gen #(
    parameter int DT_BITS = 4
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               en,
    input  logic               pwm_in,
    input  logic [DT_BITS-1:0] dt_cfg,
    output logic               hs_out,
    output logic               ls_out,
    output logic               dt_active,
    output logic               swallow
);
    typedef enum logic [2:0] {S_OFF, S_LOW, S_DT_RISE, S_HIGH, S_DT_FALL} state_t;
    state_t state_q, state_d;
    logic pwm_s_q;
    logic [DT_BITS-1:0] cnt_q, cnt_d, dt_lat_q, dt_lat_d, dt_eff;
    logic hs_q, hs_d, ls_q, ls_d, dt_q, dt_d, swallow_q, swallow_d;
    logic in_band, to_band;
    assign in_band = (state_q == S_DT_RISE) || (state_q == S_DT_FALL);
    assign to_band = (state_d == S_DT_RISE) || (state_d == S_DT_FALL);
    assign dt_eff  = (dt_cfg == '0) ? DT_BITS'(1) : dt_cfg;
    always_comb begin
        state_d   = state_q;
        swallow_d = 1'b0;
        case (state_q)
            S_OFF:     state_d = pwm_s_q ? S_DT_RISE : S_DT_FALL;
            S_LOW:     state_d = pwm_s_q ? S_DT_RISE : S_LOW;
            S_HIGH:    state_d = pwm_s_q ? S_HIGH : S_DT_FALL;
            S_DT_RISE: begin
                swallow_d = !pwm_s_q;
                state_d   = !pwm_s_q ? S_LOW : (cnt_q == DT_BITS'(1)) ? S_HIGH : S_DT_RISE;
            end
            S_DT_FALL: begin
                swallow_d = pwm_s_q;
                state_d   = pwm_s_q ? S_HIGH : (cnt_q == DT_BITS'(1)) ? S_LOW : S_DT_FALL;
            end
            default:   state_d = S_OFF;
        endcase
        // Disable is a pure turn-off: no dead band, no swallow report.
        if (!en) begin
            state_d   = S_OFF;
            swallow_d = 1'b0;
        end
        dt_lat_d = (to_band && !in_band) ? dt_eff : dt_lat_q;
        cnt_d    = (to_band && !in_band) ? dt_eff :
                   (in_band && cnt_q > DT_BITS'(1)) ? cnt_q - DT_BITS'(1) : cnt_q;
        hs_d     = state_d == S_HIGH;
        ls_d     = state_d == S_LOW;
        dt_d     = to_band;
    end
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= S_OFF;
            pwm_s_q   <= 1'b0;
            cnt_q     <= '0;
            dt_lat_q  <= '0;
            hs_q      <= 1'b0;
            ls_q      <= 1'b0;
            dt_q      <= 1'b0;
            swallow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwm_s_q   <= pwm_in;
            cnt_q     <= cnt_d;
            dt_lat_q  <= dt_lat_d;
            hs_q      <= hs_d;
            ls_q      <= ls_d;
            dt_q      <= dt_d;
            swallow_q <= swallow_d;
        end
    end
    assign hs_out    = hs_q;
    assign ls_out    = ls_q;
    assign dt_active = dt_q;
    assign swallow   = swallow_q;
endmodule
